// File: rtl/matmul_sequencer.sv
// matmul_sequencer: control sequencer for a systolic matrix-multiply array.
// It walks CLEAR -> FEED -> (BIAS) -> WB -> DONE for one operation, with
// dimensions, mode and scratchpad targets captured when the start bit is seen.
// Optional feature: define MATMUL_SEQ_BIAS_EN to include the BIAS
// (bias-row read) state. Without it, sp_rd_* outputs are tied to 0 and
// mode_bit_i / read_target_i are ignored.
module matmul_sequencer #(
   parameter int DIM_W = 2,
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_bit_i,
   input  logic             mode_bit_i,
   input  logic [1:0]       write_target_i,
   input  logic [1:0]       read_target_i,
   input  logic [DIM_W-1:0] n_dim_i,
   input  logic [DIM_W-1:0] k_dim_i,
   input  logic [DIM_W-1:0] m_dim_i,
   output logic             start_clear_o,
   output logic             busy_o,
   output logic             acc_clr_o,
   output logic             feed_en_o,
   output logic [CNT_W-1:0] feed_idx_o,
   output logic             sp_rd_en_o,
   output logic [1:0]       sp_rd_target_o,
   output logic [DIM_W-1:0] sp_rd_row_o,
   output logic             sp_wr_en_o,
   output logic [1:0]       sp_wr_target_o,
   output logic [DIM_W-1:0] sp_wr_row_o,
   output logic             done_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_WB    = 3'd3,
      S_DONE  = 3'd4
`ifdef MATMUL_SEQ_BIAS_EN
      ,
      S_BIAS  = 3'd5
`endif
   } state_t;

   state_t           state_q;

   // Shadow copies of the control register, frozen for the whole operation.
   logic [DIM_W-1:0] n_q;
   logic [DIM_W-1:0] k_q;
   logic [DIM_W-1:0] m_q;
   logic [1:0]       wr_tgt_q;
`ifdef MATMUL_SEQ_BIAS_EN
   logic             mode_q;
   logic [1:0]       rd_tgt_q;
`endif

   // Last feed index: (K+1)+(N+1)+(M+1)-2-1 = k+n+m in encoded terms.
   logic [CNT_W-1:0] feed_last;
   assign feed_last = CNT_W'(k_q) + CNT_W'(n_q) + CNT_W'(m_q);

`ifndef MATMUL_SEQ_BIAS_EN
   // Bias read port is absent in this build.
   assign sp_rd_en_o     = 1'b0;
   assign sp_rd_target_o = 2'b00;
   assign sp_rd_row_o    = '0;

   logic unused_bias_inputs;
   assign unused_bias_inputs = ^{mode_bit_i, read_target_i};
`endif

   // Sequencer FSM: state, shadow registers and all registered outputs.
   // Outputs default to 0 each cycle and are raised for the state being entered,
   // so indices and targets are 0 whenever their enable is low.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_IDLE;
         n_q            <= '0;
         k_q            <= '0;
         m_q            <= '0;
         wr_tgt_q       <= 2'b00;
`ifdef MATMUL_SEQ_BIAS_EN
         mode_q         <= 1'b0;
         rd_tgt_q       <= 2'b00;
         sp_rd_en_o     <= 1'b0;
         sp_rd_target_o <= 2'b00;
         sp_rd_row_o    <= '0;
`endif
         start_clear_o  <= 1'b0;
         busy_o         <= 1'b0;
         acc_clr_o      <= 1'b0;
         feed_en_o      <= 1'b0;
         feed_idx_o     <= '0;
         sp_wr_en_o     <= 1'b0;
         sp_wr_target_o <= 2'b00;
         sp_wr_row_o    <= '0;
         done_o         <= 1'b0;
      end else begin
         start_clear_o  <= 1'b0;
         busy_o         <= 1'b0;
         acc_clr_o      <= 1'b0;
         feed_en_o      <= 1'b0;
         feed_idx_o     <= '0;
         sp_wr_en_o     <= 1'b0;
         sp_wr_target_o <= 2'b00;
         sp_wr_row_o    <= '0;
         done_o         <= 1'b0;
`ifdef MATMUL_SEQ_BIAS_EN
         sp_rd_en_o     <= 1'b0;
         sp_rd_target_o <= 2'b00;
         sp_rd_row_o    <= '0;
`endif
         case (state_q)
            S_IDLE: begin
               if (start_bit_i) begin
                  state_q       <= S_CLEAR;
                  n_q           <= n_dim_i;
                  k_q           <= k_dim_i;
                  m_q           <= m_dim_i;
                  wr_tgt_q      <= write_target_i;
`ifdef MATMUL_SEQ_BIAS_EN
                  mode_q        <= mode_bit_i;
                  rd_tgt_q      <= read_target_i;
`endif
                  busy_o        <= 1'b1;
                  acc_clr_o     <= 1'b1;
                  start_clear_o <= 1'b1;
               end
            end
            S_CLEAR: begin
               state_q    <= S_FEED;
               busy_o     <= 1'b1;
               feed_en_o  <= 1'b1;
               feed_idx_o <= '0;
            end
            S_FEED: begin
               busy_o <= 1'b1;
               if (feed_idx_o == feed_last) begin
`ifdef MATMUL_SEQ_BIAS_EN
                  if (mode_q) begin
                     state_q        <= S_BIAS;
                     sp_rd_en_o     <= 1'b1;
                     sp_rd_target_o <= rd_tgt_q;
                     sp_rd_row_o    <= '0;
                  end else begin
                     state_q        <= S_WB;
                     sp_wr_en_o     <= 1'b1;
                     sp_wr_target_o <= wr_tgt_q;
                     sp_wr_row_o    <= '0;
                  end
`else
                  state_q        <= S_WB;
                  sp_wr_en_o     <= 1'b1;
                  sp_wr_target_o <= wr_tgt_q;
                  sp_wr_row_o    <= '0;
`endif
               end else begin
                  feed_en_o  <= 1'b1;
                  feed_idx_o <= feed_idx_o + CNT_W'(1);
               end
            end
`ifdef MATMUL_SEQ_BIAS_EN
            S_BIAS: begin
               busy_o <= 1'b1;
               if (sp_rd_row_o == n_q) begin
                  state_q        <= S_WB;
                  sp_wr_en_o     <= 1'b1;
                  sp_wr_target_o <= wr_tgt_q;
                  sp_wr_row_o    <= '0;
               end else begin
                  sp_rd_en_o     <= 1'b1;
                  sp_rd_target_o <= rd_tgt_q;
                  sp_rd_row_o    <= sp_rd_row_o + DIM_W'(1);
               end
            end
`endif
            S_WB: begin
               busy_o <= 1'b1;
               if (sp_wr_row_o == n_q) begin
                  state_q <= S_DONE;
                  done_o  <= 1'b1;
               end else begin
                  sp_wr_en_o     <= 1'b1;
                  sp_wr_target_o <= wr_tgt_q;
                  sp_wr_row_o    <= sp_wr_row_o + DIM_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed bench for matmul_sequencer. Each started
// operation pushes its expected per-cycle output trace into a queue; every
// cycle the oldest entry is popped and compared with the DUT outputs.
module tb_matmul_sequencer;

   localparam int DIM_W = 2;
   localparam int CNT_W = 4;
`ifdef MATMUL_SEQ_BIAS_EN
   localparam bit BIAS_EN = 1'b1;
`else
   localparam bit BIAS_EN = 1'b0;
`endif

   typedef struct packed {
      logic             busy;
      logic             sc;
      logic             clr;
      logic             fe;
      logic [CNT_W-1:0] idx;
      logic             re;
      logic [1:0]       rt;
      logic [DIM_W-1:0] rr;
      logic             we;
      logic [1:0]       wt;
      logic [DIM_W-1:0] wr;
      logic             done;
   } out_t;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             start_bit_i = 1'b0;
   logic             mode_bit_i = 1'b0;
   logic [1:0]       write_target_i = 2'b00;
   logic [1:0]       read_target_i = 2'b00;
   logic [DIM_W-1:0] n_dim_i = '0;
   logic [DIM_W-1:0] k_dim_i = '0;
   logic [DIM_W-1:0] m_dim_i = '0;
   logic             start_clear_o, busy_o, acc_clr_o, feed_en_o;
   logic [CNT_W-1:0] feed_idx_o;
   logic             sp_rd_en_o, sp_wr_en_o, done_o;
   logic [1:0]       sp_rd_target_o, sp_wr_target_o;
   logic [DIM_W-1:0] sp_rd_row_o, sp_wr_row_o;

   int   n_assert = 0;
   int   n_fail   = 0;
   out_t exp_q[$];

   always #5 clk_i = ~clk_i;

   matmul_sequencer #(.DIM_W(DIM_W), .CNT_W(CNT_W)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .start_bit_i    (start_bit_i),
      .mode_bit_i     (mode_bit_i),
      .write_target_i (write_target_i),
      .read_target_i  (read_target_i),
      .n_dim_i        (n_dim_i),
      .k_dim_i        (k_dim_i),
      .m_dim_i        (m_dim_i),
      .start_clear_o  (start_clear_o),
      .busy_o         (busy_o),
      .acc_clr_o      (acc_clr_o),
      .feed_en_o      (feed_en_o),
      .feed_idx_o     (feed_idx_o),
      .sp_rd_en_o     (sp_rd_en_o),
      .sp_rd_target_o (sp_rd_target_o),
      .sp_rd_row_o    (sp_rd_row_o),
      .sp_wr_en_o     (sp_wr_en_o),
      .sp_wr_target_o (sp_wr_target_o),
      .sp_wr_row_o    (sp_wr_row_o),
      .done_o         (done_o)
   );

   function automatic out_t sample();
      out_t o;
      o.busy = busy_o;        o.sc = start_clear_o;   o.clr = acc_clr_o;
      o.fe   = feed_en_o;     o.idx = feed_idx_o;
      o.re   = sp_rd_en_o;    o.rt = sp_rd_target_o;  o.rr = sp_rd_row_o;
      o.we   = sp_wr_en_o;    o.wt = sp_wr_target_o;  o.wr = sp_wr_row_o;
      o.done = done_o;
      return o;
   endfunction

   // Reference trace of one operation from actual dimensions, plus one idle cycle.
   function automatic void push_trace(input int n, input int k, input int m,
                                      input bit mode, input logic [1:0] rd,
                                      input logic [1:0] wr);
      out_t e;
      e = '0; e.busy = 1'b1; e.sc = 1'b1; e.clr = 1'b1;
      exp_q.push_back(e);
      for (int i = 0; i < k + n + m - 2; i++) begin
         e = '0; e.busy = 1'b1; e.fe = 1'b1; e.idx = CNT_W'(i);
         exp_q.push_back(e);
      end
      if (mode && BIAS_EN) begin
         for (int r = 0; r < n; r++) begin
            e = '0; e.busy = 1'b1; e.re = 1'b1; e.rt = rd; e.rr = DIM_W'(r);
            exp_q.push_back(e);
         end
      end
      for (int r = 0; r < n; r++) begin
         e = '0; e.busy = 1'b1; e.we = 1'b1; e.wt = wr; e.wr = DIM_W'(r);
         exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.done = 1'b1;
      exp_q.push_back(e);
      exp_q.push_back('0);
   endfunction

   task automatic check(input string tag);
      out_t e, o;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : out_t'('0);
      o = sample();
      n_assert++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic check_zero(input string tag);
      n_assert++;
      assert (sample() === out_t'('0)) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, sample(), out_t'('0));
      end
   endtask

   // Drive the control register for a new operation (encoded dims) and queue its trace.
   task automatic start_op(input int n, input int k, input int m, input bit mode,
                           input logic [1:0] rd, input logic [1:0] wr);
      push_trace(n + 1, k + 1, m + 1, mode, rd, wr);
      @(negedge clk_i);
      n_dim_i = DIM_W'(n); k_dim_i = DIM_W'(k); m_dim_i = DIM_W'(m);
      mode_bit_i = mode; read_target_i = rd; write_target_i = wr;
      start_bit_i = 1'b1;
   endtask

   // Step cycles until the expected queue drains. Optional events: release of
   // start, an n_dim_i change, and an asynchronous reset abort.
   task automatic run_op(input string tag, input int rel_at, input int chg_at,
                         input logic [DIM_W-1:0] chg_n, input int abort_at);
      for (int c = 0; exp_q.size() > 0 && c < 200; c++) begin
         @(negedge clk_i);
         if (c == rel_at) start_bit_i = 1'b0;
         if (c == chg_at) n_dim_i = chg_n;
         check(tag);
         if (c == abort_at) begin
            #1 rst_ni = 1'b0;
            #1 check_zero({tag, "_rst_now"});
            exp_q.delete();
            break;
         end
      end
      n_assert++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL %s_drain: observed=%0d expected=0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      int len1;
      // Reset state.
      repeat (2) @(negedge clk_i);
      check_zero("reset_hold");
      rst_ni = 1'b1;
      @(negedge clk_i);
      check_zero("idle_after_reset");

      // Minimum case N=K=M=1, no bias.
      start_op(0, 0, 0, 1'b0, 2'd0, 2'd0);
      run_op("min_111", 0, -1, '0, -1);

      // N=2,K=3,M=4, bias on, read 2, write 3.
      start_op(1, 2, 3, 1'b1, 2'd2, 2'd3);
      run_op("n2k3m4_bias", 0, -1, '0, -1);

      // Maximum case N=K=M=4 with bias.
      start_op(3, 3, 3, 1'b1, 2'd1, 2'd2);
      run_op("max_444", 0, -1, '0, -1);

      // n_dim_i changed mid-FEED must not change the row count.
      start_op(1, 3, 3, 1'b0, 2'd0, 2'd1);
      run_op("shadow_n", 0, 3, 2'd3, -1);

      // Reset at feed_idx 3 (CLEAR is cycle 0, idx 3 is cycle 4).
      start_op(3, 3, 3, 1'b0, 2'd0, 2'd2);
      run_op("abort", 0, -1, '0, 4);
      repeat (3) begin
         @(negedge clk_i);
         check_zero("in_reset");
      end
      rst_ni = 1'b1;
      repeat (2) begin
         @(negedge clk_i);
         check_zero("no_done_after_abort");
      end
      start_op(1, 2, 3, 1'b1, 2'd2, 2'd3);
      run_op("after_abort", 0, -1, '0, -1);

      // Start held high through DONE: one idle cycle, then a single restart.
      start_op(0, 1, 0, 1'b1, 2'd3, 2'd1);
      len1 = exp_q.size();
      push_trace(1, 2, 1, 1'b1, 2'd3, 2'd1);
      run_op("hold_start", len1, -1, '0, -1);
      repeat (3) begin
         @(negedge clk_i);
         check_zero("idle_tail");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter DIM_W, default 2: width of each encoded dimension field; actual dimension = field+1.
REQ-002 SHALL have parameter CNT_W, default 4: width of the feed-cycle counter; SHALL hold 3*(2**DIM_W)-2.
REQ-003 clk_i  in  1  clock, rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 start_bit_i  in  1  start bit from the control register.
REQ-006 mode_bit_i  in  1  bias-add enable from the control register.
REQ-007 write_target_i, read_target_i  in  2 each  scratchpad targets from the control register.
REQ-008 n_dim_i, k_dim_i, m_dim_i  in  DIM_W each  encoded N, K, M dimensions.
REQ-009 start_clear_o  out  1  one-cycle pulse requesting the control register to de-assert its start bit.
REQ-010 busy_o  out  1  high in every state except IDLE.
REQ-011 acc_clr_o  out  1  clears the processing-element accumulators.
REQ-012 feed_en_o  out  1  operand-feed strobe to the array; feed_idx_o  out  CNT_W  current feed cycle.
REQ-013 sp_rd_en_o, sp_rd_target_o[1:0], sp_rd_row_o[DIM_W-1:0]  out  scratchpad bias-row read request.
REQ-014 sp_wr_en_o, sp_wr_target_o[1:0], sp_wr_row_o[DIM_W-1:0]  out  scratchpad result-row write request.
REQ-015 done_o  out  1  one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, FEED, BIAS, WB, DONE; one state per cycle unless a count is stated.
REQ-017 IDLE->CLEAR when start_bit_i=1 at the clock edge; start_bit_i is ignored in all other states.
REQ-018 On IDLE->CLEAR, dims, mode bit and both targets SHALL be latched into shadow registers; later input changes SHALL NOT affect the running operation.
REQ-019 CLEAR lasts 1 cycle with acc_clr_o=1 and start_clear_o=1.
REQ-020 FEED lasts L=K+N+M-2 cycles (actual dims); feed_en_o=1; feed_idx_o counts 0..L-1.
REQ-021 After FEED: go to BIAS if the latched mode bit=1, else to WB.
REQ-022 BIAS lasts N cycles; sp_rd_en_o=1, sp_rd_target_o=latched read target, sp_rd_row_o=0..N-1.
REQ-023 WB lasts N cycles; sp_wr_en_o=1, sp_wr_target_o=latched write target, sp_wr_row_o=0..N-1.
REQ-024 DONE lasts 1 cycle with done_o=1, then goes to IDLE; start_bit_i high in DONE SHALL NOT restart the sequence.
REQ-025 All enable/strobe outputs SHALL be 0 outside their named states; row/index/target outputs SHALL be 0 when their enable is 0.
REQ-026 Minimum case N=K=M=1: L=1; total busy duration 1+1+1+1 = 4 cycles without bias.
REQ-027 Maximum case N=K=M=4: L=10; counters SHALL NOT wrap.

Reset
REQ-028 Reset SHALL force state IDLE and set all outputs and shadow registers to 0, in any state including mid-FEED; no done_o pulse follows an aborted operation.
REQ-029 After reset release, a new start SHALL be accepted on the first clock edge with start_bit_i=1.

Configuration
REQ-030 Macro MATMUL_SEQ_BIAS_EN defined: BIAS state present as in REQ-021/REQ-022.
REQ-031 Macro MATMUL_SEQ_BIAS_EN undefined: BIAS state and sp_rd_* logic removed; sp_rd_en_o, sp_rd_target_o and sp_rd_row_o tied to 0; FEED always goes to WB; mode_bit_i ignored.

Verification
REQ-032 N=K=M=1, mode=0, start pulse -> CLEAR 1 cycle with start_clear_o=1, feed_en_o 1 cycle, sp_wr_en_o 1 cycle row 0, done_o on the 4th cycle after start.
REQ-033 N=2,K=3,M=4 (enc 1,2,3), mode=1, read=2, write=3 -> feed_en_o 7 cycles idx 0..6, sp_rd_en_o rows 0,1 target 2, sp_wr_en_o rows 0,1 target 3, done_o.
REQ-034 N=K=M=4, mode=1 -> feed 10 cycles, BIAS 4, WB 4, busy_o high for 20 cycles.
REQ-035 Change n_dim_i from 1 to 3 during FEED -> WB still writes 2 rows.
REQ-036 rst_ni low at feed_idx_o=3 -> all outputs 0 immediately, no done_o; start after release -> full sequence from CLEAR.
REQ-037 start_bit_i held high through DONE -> returns to IDLE, restarts only on the next edge with start_bit_i=1 in IDLE; macro undefined with mode=1 -> no sp_rd_en_o, WB follows FEED directly.
